// File: rtl/ram_march_bist.sv
// ram_march_bist
//   March C- built-in self-test sequencer for a single-port RAM with a registered read.
//   It drives the RAM pins directly, runs the sequence
//     up(w0) ; up(r0,w1) ; down(r1,w0) ; up(r0)
//   and compares every read against the expected background.
//   Results are pass, first-failure address and data, and a saturating error count.
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   start        request to begin a run; sampled only in IDLE
//   busy         high from the cycle after start is accepted until DONE
//   done         one-cycle pulse in the DONE state
//   pass         1 = last run saw no mismatch; valid from done until the next start
//   fail_addr    address of the first mismatch
//   fail_data    read data captured at the first mismatch
//   err_cnt      mismatch count; saturates at all-ones
//   mem_en/mem_we/mem_addr/mem_wdata   RAM command pins (registered)
//   mem_rdata    RAM read data, valid the cycle after a read is issued
//   dbg_state    current FSM state, for checkers
//
// Handshake: start is a level sampled at every clock edge while in IDLE.
// A 1 seen there launches exactly one run. start is ignored in all other states.
// done marks the single cycle in which the results become valid.

module ram_march_bist #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W0_UP   = 3'd1,
        S_R0W1_UP = 3'd2,
        S_R1W0_DN = 3'd3,
        S_R0_UP   = 3'd4,
        S_CHK     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    state_t                  state;
    logic                    second;   // second cycle (write) of a read-write element
    logic                    rd_pend;  // a read was issued last cycle; compare it now
    logic                    rd_ones;  // that read expects all-ones
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    mismatch;
    logic [CNT_WIDTH-1:0]    err_next;

    assign dbg_state = state;

    // Every read is compared exactly one cycle after it was issued, whatever the phase.
    always_comb begin
        mismatch = rd_pend && (mem_rdata != (rd_ones ? {WIDTH{1'b1}} : {WIDTH{1'b0}}));
        err_next = err_cnt;
        if (mismatch && !(&err_cnt)) begin
            err_next = err_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            second    <= 1'b0;
            rd_pend   <= 1'b0;
            rd_ones   <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            err_cnt   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done    <= 1'b0;
            // Arm the compare for whatever read is on the pins this cycle.
            rd_pend <= mem_en && !mem_we;
            rd_addr <= mem_addr;
            rd_ones <= (state == S_R1W0_DN);

            if (mismatch) begin
                err_cnt <= err_next;
                if (err_cnt == '0) begin
                    fail_addr <= rd_addr;
                    fail_data <= mem_rdata;
                end
            end

            // The mem_* registers hold the operation for the next cycle.
            case (state)
                S_IDLE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (start) begin
                        state     <= S_W0_UP;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end

                S_W0_UP: begin
                    if (mem_addr == LAST_ADDR) begin
                        state    <= S_R0W1_UP;
                        second   <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end

                S_R0W1_UP: begin
                    if (!second) begin
                        second    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= '1;
                    end else begin
                        second <= 1'b0;
                        mem_we <= 1'b0;
                        if (mem_addr == LAST_ADDR) begin
                            state <= S_R1W0_DN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_ONE;
                        end
                    end
                end

                S_R1W0_DN: begin
                    if (!second) begin
                        second    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= '0;
                    end else begin
                        second <= 1'b0;
                        mem_we <= 1'b0;
                        if (mem_addr == '0) begin
                            state <= S_R0_UP;
                        end else begin
                            mem_addr <= mem_addr - ADDR_ONE;
                        end
                    end
                end

                S_R0_UP: begin
                    if (mem_addr == LAST_ADDR) begin
                        state  <= S_CHK;
                        mem_en <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + ADDR_ONE;
                    end
                end

                S_CHK: begin
                    // The final R0 compare lands in this cycle, so pass uses err_next.
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
module tb_ram_march_bist;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A: DEPTH=16, CNT_WIDTH=8 ----------------
  logic       start_a = 1'b0;
  logic       busy_a, done_a, pass_a;
  logic [3:0] fail_addr_a;
  logic [7:0] fail_data_a, err_a;
  logic       mem_en_a, mem_we_a;
  logic [3:0] mem_addr_a;
  logic [7:0] mem_wdata_a, rdata_a;
  logic [2:0] dbg_a;

  ram_march_bist #(.WIDTH(8), .DEPTH(16), .CNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(fail_addr_a), .fail_data(fail_data_a), .err_cnt(err_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(rdata_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B: DEPTH=10, CNT_WIDTH=2 ----------------
  logic       start_b = 1'b0;
  logic       busy_b, done_b, pass_b;
  logic [3:0] fail_addr_b;
  logic [7:0] fail_data_b;
  logic [1:0] err_b;
  logic       mem_en_b, mem_we_b;
  logic [3:0] mem_addr_b;
  logic [7:0] mem_wdata_b, rdata_b;
  logic [2:0] dbg_b;

  ram_march_bist #(.WIDTH(8), .DEPTH(10), .CNT_WIDTH(2)) u_dut10 (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_data(fail_data_b), .err_cnt(err_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(rdata_b), .dbg_state(dbg_b)
  );

  // ---------------- behavioural RAMs with fault injection ----------------
  logic [7:0] ram_a [16];
  logic [7:0] ram_b [16];
  logic       sa1_en = 0, sa0_en = 0, cpl_en = 0, broken_b = 0;
  logic [3:0] sa1_addr = 0, sa0_addr = 0;
  logic [7:0] sa1_mask = 0, sa0_mask = 0;

  function automatic logic [7:0] fault_rd(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (sa1_en && a == sa1_addr) r = r | sa1_mask;
    if (sa0_en && a == sa0_addr) r = r & ~sa0_mask;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) begin
        ram_a[mem_addr_a] <= mem_wdata_a;
        if (cpl_en && mem_addr_a == 4'd3) ram_a[4] <= ~ram_a[4];
      end else begin
        rdata_a <= fault_rd(mem_addr_a, ram_a[mem_addr_a]);
      end
    end
  end

  always @(posedge clk) begin
    if (mem_en_b) begin
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      else          rdata_b <= broken_b ? 8'h55 : ram_b[mem_addr_b];
    end
  end

  // ---------------- counters and check helper ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- result scoreboard ----------------
  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic       atleast;
    logic [3:0] fa;
    logic [7:0] fd;
  } res_t;
  res_t exp_q[$];

  // ---------------- RAM command scoreboard (DUT A) ----------------
  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } op_t;
  op_t op_q[$];
  logic op_chk = 1'b0;

  always @(negedge clk) begin : op_mon
    op_t e;
    if (op_chk && mem_en_a) begin
      if (op_q.size() == 0) begin
        check("op_extra", 32'(mem_en_a), 32'd0);
      end else begin
        e = op_q.pop_front();
        check("op_we", 32'(mem_we_a), 32'(e.we));
        check("op_addr", 32'(mem_addr_a), 32'(e.addr));
        if (e.we) check("op_wdata", 32'(mem_wdata_a), 32'(e.wdata));
      end
    end
  end

  // ---------------- address range monitor (DUT B) ----------------
  int b_max = 0;
  int b_oob = 0;
  always @(negedge clk) begin
    if (mem_en_b) begin
      if (int'(mem_addr_b) > b_max) b_max <= int'(mem_addr_b);
      if (mem_addr_b >= 4'd10) b_oob <= b_oob + 1;
    end
  end

  // ---------------- driver: one BIST run, results popped at done ----------------
  task automatic run_bist(input bit sel, input bit hold, output int done_cyc, output int busy_cnt);
    res_t e;
    done_cyc = 0;
    busy_cnt = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    for (int i = 1; i <= 400; i++) begin
      if (sel ? done_b : done_a) begin
        done_cyc = i;
        break;
      end
      if (sel ? busy_b : busy_a) busy_cnt++;
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (done_cyc == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("busy_at_done", 32'(sel ? busy_b : busy_a), 32'd0);
      check("pass", 32'(sel ? pass_b : pass_a), 32'(e.pass));
      if (e.atleast) check("err_nonzero", 32'((sel ? {6'd0, err_b} : err_a) != 8'd0), 32'd1);
      else           check("err_cnt", 32'(sel ? {6'd0, err_b} : err_a), 32'(e.err));
      check("fail_addr", 32'(sel ? fail_addr_b : fail_addr_a), 32'(e.fa));
      check("fail_data", 32'(sel ? fail_data_b : fail_data_a), 32'(e.fd));
      @(posedge clk); #1;
      check("done_one_cycle", 32'(sel ? done_b : done_a), 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       sa1_en;  logic [3:0] sa1_addr; logic [7:0] sa1_mask;
    logic       sa0_en;  logic [3:0] sa0_addr; logic [7:0] sa0_mask;
    logic       cpl_en;
    res_t       exp;
  } vec_t;
  vec_t vecs[6];

  int dc, bc;
  int b_max_prev;

  initial begin
    vecs[0] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, '{1'b1, 8'd0, 1'b0, 4'd0, 8'h00}};
    vecs[1] = '{1, 4'd5, 8'h08, 0, 4'd0, 8'h00, 0, '{1'b0, 8'd2, 1'b0, 4'd5, 8'h08}};
    vecs[2] = '{0, 4'd0, 8'h00, 1, 4'd15, 8'h01, 0, '{1'b0, 8'd1, 1'b0, 4'd15, 8'hFE}};
    vecs[3] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, '{1'b0, 8'd0, 1'b1, 4'd4, 8'hFF}};
    vecs[4] = '{1, 4'd0, 8'h80, 0, 4'd0, 8'h00, 0, '{1'b0, 8'd2, 1'b0, 4'd0, 8'h80}};
    vecs[5] = '{0, 4'd0, 8'h00, 1, 4'd7, 8'hFF, 0, '{1'b0, 8'd1, 1'b0, 4'd7, 8'h00}};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", 32'({busy_a, done_a, pass_a, fail_addr_a, fail_data_a, err_a,
                               mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}), 32'd0);
    check("reset_outs_b", 32'({busy_b, done_b, pass_b, fail_addr_b, fail_data_b, err_b,
                               mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b}), 32'd0);
    check("reset_state_a", 32'(dbg_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven fault runs on DUT A; the clean run also checks every RAM command
    for (int v = 0; v < 6; v++) begin
      sa1_en = vecs[v].sa1_en; sa1_addr = vecs[v].sa1_addr; sa1_mask = vecs[v].sa1_mask;
      sa0_en = vecs[v].sa0_en; sa0_addr = vecs[v].sa0_addr; sa0_mask = vecs[v].sa0_mask;
      cpl_en = vecs[v].cpl_en;
      if (v == 0) begin
        for (int a = 0; a < 16; a++) op_q.push_back('{1'b1, 4'(a), 8'h00});
        for (int a = 0; a < 16; a++) begin
          op_q.push_back('{1'b0, 4'(a), 8'h00});
          op_q.push_back('{1'b1, 4'(a), 8'hFF});
        end
        for (int a = 15; a >= 0; a--) begin
          op_q.push_back('{1'b0, 4'(a), 8'h00});
          op_q.push_back('{1'b1, 4'(a), 8'h00});
        end
        for (int a = 0; a < 16; a++) op_q.push_back('{1'b0, 4'(a), 8'h00});
        op_chk = 1'b1;
      end
      exp_q.push_back(vecs[v].exp);
      run_bist(1'b0, 1'b0, dc, bc);
      check("done_cycle", 32'(dc), 32'd98);
      check("busy_cycles", 32'(bc), 32'd97);
      if (v == 0) begin
        op_chk = 1'b0;
        check("op_remaining", 32'(op_q.size()), 32'd0);
      end
      repeat (2) @(posedge clk);
    end
    sa1_en = 0; sa0_en = 0; cpl_en = 0;

    // reset mid-run: outputs drop immediately, no done follows
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (39) @(posedge clk);
    #3;
    check("busy_before_abort", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_outs", 32'({busy_a, done_a, pass_a, fail_addr_a, fail_data_a, err_a,
                             mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}), 32'd0);
    check("abort_state", 32'(dbg_a), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) dc++;
    end
    check("no_activity_after_abort", 32'(dc), 32'd0);

    // fresh start after the abort is a full clean run
    exp_q.push_back('{1'b1, 8'd0, 1'b0, 4'd0, 8'h00});
    run_bist(1'b0, 1'b0, dc, bc);
    check("restart_done_cycle", 32'(dc), 32'd98);
    check("restart_busy_cycles", 32'(bc), 32'd97);

    // start held high through the whole run launches exactly one run
    exp_q.push_back('{1'b1, 8'd0, 1'b0, 4'd0, 8'h00});
    run_bist(1'b0, 1'b1, dc, bc);
    check("held_done_cycle", 32'(dc), 32'd98);
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy_a || done_a) dc++;
    end
    check("held_single_run", 32'(dc), 32'd0);

    // DEPTH=10: shorter run, addresses stay below 10
    exp_q.push_back('{1'b1, 8'd0, 1'b0, 4'd0, 8'h00});
    run_bist(1'b1, 1'b0, dc, bc);
    check("d10_done_cycle", 32'(dc), 32'd62);
    check("d10_busy_cycles", 32'(bc), 32'd61);
    @(negedge clk);
    check("d10_max_addr", 32'(b_max), 32'd9);
    check("d10_out_of_range", 32'(b_oob), 32'd0);

    // every read wrong: 30 mismatches saturate a 2-bit counter at 3
    broken_b = 1'b1;
    exp_q.push_back('{1'b0, 8'd3, 1'b0, 4'd0, 8'h55});
    run_bist(1'b1, 1'b0, dc, bc);
    check("sat_done_cycle", 32'(dc), 32'd62);
    broken_b = 1'b0;
    @(negedge clk);
    check("sat_out_of_range", 32'(b_oob), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
